// File: rtl/dot_matrix_scheduler.sv
// dot_matrix_scheduler
// Chooses which 8x8 dot-matrix symbol is shown and for how long. Result
// events from the input checker and the answer checker are queued in a small
// FIFO; each one is shown for HOLD_TICKS cycles, followed by GAP_TICKS blank
// cycles.
//
// Build option: DOT_BLINK_EN -- when defined, disp_on blinks during SHOW with
// a half-period of BLINK_TICKS cycles. When undefined, disp_on == sym_valid.
//
// Ports
//   i_clk_div    display clock, rising edge
//   i_rst        asynchronous active-low reset
//   i_clear      synchronous flush (FIFO, state, overflow)
//   i_in_valid   input-check result pulse,  i_in_ok  (1 ok / 0 error)
//   i_ans_valid  answer-check result pulse, i_ans_ok (1 correct / 0 wrong)
//   o_sym        symbol code: 0 wrong, 1 correct, 2 error, 3 ok
//   o_sym_valid  high while a symbol is being shown
//   o_disp_on    scan driver enable
//   o_busy       state != IDLE or FIFO not empty
//   o_overflow   sticky: an event was dropped on a full FIFO
//
// state | meaning
// IDLE  | nothing shown, waiting for a queued event
// SHOW  | symbol displayed, hold timer running
// GAP   | matrix blanked, gap timer running

module dot_matrix_scheduler #(
    parameter int CNT_W       = 16,
    parameter int HOLD_TICKS  = 1000,
    parameter int GAP_TICKS   = 100,
    parameter int DEPTH       = 4,
    parameter int BLINK_TICKS = 125
) (
    input  logic       i_clk_div,
    input  logic       i_rst,
    input  logic       i_clear,
    input  logic       i_in_valid,
    input  logic       i_in_ok,
    input  logic       i_ans_valid,
    input  logic       i_ans_ok,
    output logic [1:0] o_sym,
    output logic       o_sym_valid,
    output logic       o_disp_on,
    output logic       o_busy,
    output logic       o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SHOW = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    logic [1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_tick;
    logic [1:0]       r_sym;

    logic             w_empty;
    logic             w_tc;
    logic             w_pop;
    logic [PTR_W+1:0] w_free;
    logic             w_req0;
    logic             w_req1;
    logic [1:0]       w_ev0;
    logic [1:0]       w_ev1;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_drop;
    logic [PTR_W-1:0] w_wptr_nx;

    assign w_empty = (r_count == '0);
    assign w_tc    = (r_tick == '0);

    // Pop whenever the FSM is about to (re)enter SHOW.
    assign w_pop = !i_clear && !w_empty &&
                   ((r_state == S_IDLE) ||
                    (r_state == S_GAP  && w_tc) ||
                    (r_state == S_SHOW && w_tc && GAP_TICKS == 0));

    // Free slots include the one released by a same-cycle pop.
    assign w_free = (PTR_W+2)'(DEPTH) - (PTR_W+2)'(r_count) + (PTR_W+2)'(w_pop);

    // Input-check event goes first when both arrive together.
    assign w_req0 = i_in_valid | i_ans_valid;
    assign w_req1 = i_in_valid & i_ans_valid;
    assign w_ev0  = i_in_valid ? {1'b1, i_in_ok} : {1'b0, i_ans_ok};
    assign w_ev1  = {1'b0, i_ans_ok};

    assign w_acc0    = !i_clear && w_req0 && (w_free != '0);
    assign w_acc1    = !i_clear && w_req1 && (w_free >= (PTR_W+2)'(2));
    assign w_drop    = !i_clear && ((w_req0 && !w_acc0) || (w_req1 && !w_acc1));
    assign w_wptr_nx = r_wptr + PTR_W'(1);

    always_ff @(posedge i_clk_div) begin
        if (w_acc0) r_mem[r_wptr]    <= w_ev0;
        if (w_acc1) r_mem[w_wptr_nx] <= w_ev1;
    end

    always_ff @(posedge i_clk_div or negedge i_rst) begin
        if (!i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wptr     <= r_wptr + PTR_W'(w_acc0) + PTR_W'(w_acc1);
            r_rptr     <= r_rptr + PTR_W'(w_pop);
            r_count    <= r_count + (PTR_W+1)'(w_acc0) + (PTR_W+1)'(w_acc1)
                          - (PTR_W+1)'(w_pop);
            r_overflow <= r_overflow | w_drop;
        end
    end

    always_ff @(posedge i_clk_div or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
        end else if (i_clear) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_SHOW;
                        r_tick  <= HOLD_LD;
                    end
                end
                S_SHOW: begin
                    if (!w_tc) begin
                        r_tick <= r_tick - CNT_W'(1);
                    end else if (GAP_TICKS > 0) begin
                        r_state <= S_GAP;
                        r_tick  <= GAP_LD;
                    end else if (w_pop) begin
                        r_tick <= HOLD_LD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (!w_tc) begin
                        r_tick <= r_tick - CNT_W'(1);
                    end else if (w_pop) begin
                        r_state <= S_SHOW;
                        r_tick  <= HOLD_LD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tick  <= '0;
                end
            endcase
        end
    end

    // sym keeps the last shown code; clear does not touch it.
    always_ff @(posedge i_clk_div or negedge i_rst) begin
        if (!i_rst) begin
            r_sym <= 2'd0;
        end else if (w_pop) begin
            r_sym <= r_mem[r_rptr];
        end
    end

    assign o_sym       = r_sym;
    assign o_sym_valid = (r_state == S_SHOW);
    assign o_busy      = (r_state != S_IDLE) || !w_empty;
    assign o_overflow  = r_overflow;

`ifdef DOT_BLINK_EN
    localparam logic [CNT_W-1:0] BLINK_LD = CNT_W'(BLINK_TICKS - 1);

    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_blink_on;

    // Every pop starts a fresh SHOW, so the blink phase restarts there.
    always_ff @(posedge i_clk_div or negedge i_rst) begin
        if (!i_rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
        end else if (i_clear) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
        end else if (w_pop) begin
            r_blink_cnt <= BLINK_LD;
            r_blink_on  <= 1'b1;
        end else if (r_state == S_SHOW) begin
            if (r_blink_cnt == '0) begin
                r_blink_cnt <= BLINK_LD;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt - CNT_W'(1);
            end
        end
    end

    assign o_disp_on = r_blink_on && (r_state == S_SHOW);
`else
    assign o_disp_on = o_sym_valid;
`endif

endmodule

// File: tb/tb_dot_matrix_scheduler.sv
module tb_dot_matrix_scheduler;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       clear     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_ok     = 1'b0;
    logic       ans_valid = 1'b0;
    logic       ans_ok    = 1'b0;
    logic [1:0] sym;
    logic       sym_valid;
    logic       disp_on;
    logic       busy;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] sb [$];
    logic       prev_sv = 1'b0;
    int         show_len = 0;
    logic       abort_show = 1'b0;
    logic [3:0] blink_pat;

    dot_matrix_scheduler #(
        .CNT_W      (16),
        .HOLD_TICKS (4),
        .GAP_TICKS  (2),
        .DEPTH      (4),
        .BLINK_TICKS(2)
    ) dut (
        .i_clk_div  (clk),
        .i_rst      (rst_n),
        .i_clear    (clear),
        .i_in_valid (in_valid),
        .i_in_ok    (in_ok),
        .i_ans_valid(ans_valid),
        .i_ans_ok   (ans_ok),
        .o_sym      (sym),
        .o_sym_valid(sym_valid),
        .o_disp_on  (disp_on),
        .o_busy     (busy),
        .o_overflow (overflow)
    );

    always #5 clk = ~clk;

    // One rising edge, then sample at the falling edge and run the scoreboard.
    task automatic cyc();
        logic [1:0] exp_sym;
        @(negedge clk);
        if (sym_valid && !prev_sv) begin
            show_len = 1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_show got sym=%0d, no symbol queued", sym);
            end else begin
                exp_sym = sb.pop_front();
                if (sym !== exp_sym) begin
                    errors++;
                    $display("FAIL sb_sym got %0d expected %0d", sym, exp_sym);
                end
            end
        end else if (sym_valid) begin
            show_len++;
        end
        if (sym_valid && show_len >= 1 && show_len <= 4) begin
            checks++;
            if (disp_on !== blink_pat[4-show_len]) begin
                errors++;
                $display("FAIL show_disp_on cycle %0d got %b expected %b",
                         show_len, disp_on, blink_pat[4-show_len]);
            end
        end
        if (!sym_valid) begin
            checks++;
            if (disp_on !== 1'b0) begin
                errors++;
                $display("FAIL blank_disp_on got %b expected 0", disp_on);
            end
        end
        if (!sym_valid && prev_sv) begin
            if (abort_show) begin
                abort_show = 1'b0;
            end else begin
                checks++;
                if (show_len !== 4) begin
                    errors++;
                    $display("FAIL hold_len got %0d expected 4", show_len);
                end
            end
        end
        prev_sv = sym_valid;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 60) begin
            cyc();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout busy=%b expected 0", name, busy);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_left got %0d entries expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({sym, sym_valid, disp_on, busy, overflow} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 000000",
                     {sym, sym_valid, disp_on, busy, overflow});
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({sym, sym_valid, disp_on, busy, overflow} !== 6'b0) begin
            errors++;
            $display("FAIL reset_held got %b expected 000000",
                     {sym, sym_valid, disp_on, busy, overflow});
        end
        rst_n = 1'b1;
        cyc();
        checks++;
        if ({sym_valid, busy, overflow} !== 3'b0) begin
            errors++;
            $display("FAIL reset_release got %b expected 000", {sym_valid, busy, overflow});
        end
    endtask

    task automatic test_single();
        ans_valid = 1'b1; ans_ok = 1'b1; sb.push_back(2'd1);
        cyc();
        ans_valid = 1'b0;
        checks++;
        if (sym_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_e0 got sv=%b busy=%b expected sv=0 busy=1", sym_valid, busy);
        end
        cyc();
        checks++;
        if (sym_valid !== 1'b1 || sym !== 2'd1) begin
            errors++;
            $display("FAIL single_e1 got sv=%b sym=%0d expected sv=1 sym=1", sym_valid, sym);
        end
        repeat (3) cyc();
        checks++;
        if (sym_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_hold4 got sv=%b expected 1", sym_valid);
        end
        for (int g = 0; g < 2; g++) begin
            cyc();
            checks++;
            if (sym_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_gap%0d got sv=%b busy=%b expected sv=0 busy=1",
                         g, sym_valid, busy);
            end
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || sym !== 2'd1) begin
            errors++;
            $display("FAIL single_idle got busy=%b sym=%0d expected busy=0 sym=1", busy, sym);
        end
    endtask

    task automatic test_simultaneous();
        in_valid = 1'b1; in_ok = 1'b0; ans_valid = 1'b1; ans_ok = 1'b0;
        sb.push_back(2'd2);
        sb.push_back(2'd0);
        cyc();
        in_valid = 1'b0; ans_valid = 1'b0;
        wait_idle("simul");
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL simul_overflow got %b expected 0", overflow);
        end
    endtask

    task automatic test_overflow();
        logic       pin  [3];
        logic       pans [3];
        int         cnt;
        logic       exp_ovf;
        pin[0] = 1'b1; pans[0] = 1'b1;
        pin[1] = 1'b0; pans[1] = 1'b0;
        pin[2] = 1'b1; pans[2] = 1'b0;
        ans_valid = 1'b1; ans_ok = 1'b1; sb.push_back(2'd1);
        cyc();
        ans_valid = 1'b0;
        cyc();
        cnt = 0;
        exp_ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_ok = pin[i]; ans_valid = 1'b1; ans_ok = pans[i];
            if (cnt < 4) begin sb.push_back({1'b1, pin[i]}); cnt++; end
            else exp_ovf = 1'b1;
            if (cnt < 4) begin sb.push_back({1'b0, pans[i]}); cnt++; end
            else exp_ovf = 1'b1;
            cyc();
        end
        in_valid = 1'b0; ans_valid = 1'b0;
        checks++;
        if (overflow !== exp_ovf) begin
            errors++;
            $display("FAIL ovf_set got %b expected %b", overflow, exp_ovf);
        end
        wait_idle("ovf");
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b expected 1", overflow);
        end
    endtask

    task automatic test_clear();
        in_valid = 1'b1; in_ok = 1'b1; ans_valid = 1'b1; ans_ok = 1'b1;
        sb.push_back(2'd3);
        cyc();
        in_valid = 1'b0; ans_valid = 1'b1; ans_ok = 1'b0;
        cyc();
        ans_valid = 1'b0;
        cyc();
        clear = 1'b1; in_valid = 1'b1; in_ok = 1'b0; abort_show = 1'b1;
        cyc();
        clear = 1'b0; in_valid = 1'b0;
        checks++;
        if ({sym_valid, busy, overflow, disp_on} !== 4'b0) begin
            errors++;
            $display("FAIL clear_flush got sv/busy/ovf/disp=%b expected 0000",
                     {sym_valid, busy, overflow, disp_on});
        end
        repeat (6) cyc();
        checks++;
        if (busy !== 1'b0 || sym_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_discard got busy=%b sv=%b expected 0 0", busy, sym_valid);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL clear_sb got %0d entries expected 0", sb.size());
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_ok = 1'b1; sb.push_back(2'd3);
        cyc();
        in_valid = 1'b0;
        cyc();
        ans_valid = 1'b1; ans_ok = 1'b0;
        cyc();
        ans_valid = 1'b0;
        repeat (3) cyc();
        checks++;
        if (sym_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL arst_in_gap got sv=%b busy=%b expected 0 1", sym_valid, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sym, sym_valid, disp_on, busy, overflow} !== 6'b0) begin
            errors++;
            $display("FAIL arst_immediate got %b expected 000000",
                     {sym, sym_valid, disp_on, busy, overflow});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        cyc();
        checks++;
        if (busy !== 1'b0 || sym_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_lost got busy=%b sv=%b expected 0 0", busy, sym_valid);
        end
        ans_valid = 1'b1; ans_ok = 1'b0; sb.push_back(2'd0);
        cyc();
        ans_valid = 1'b0;
        checks++;
        if (sym_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_new_e0 got sv=%b expected 0", sym_valid);
        end
        cyc();
        checks++;
        if (sym_valid !== 1'b1 || sym !== 2'd0) begin
            errors++;
            $display("FAIL arst_new_e1 got sv=%b sym=%0d expected 1 0", sym_valid, sym);
        end
        wait_idle("arst");
    endtask

    task automatic test_blink();
        logic [3:0] pat;
        pat = 4'b0;
        in_valid = 1'b1; in_ok = 1'b0; sb.push_back(2'd2);
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            pat = {pat[2:0], disp_on};
        end
        checks++;
        if (pat !== blink_pat) begin
            errors++;
            $display("FAIL blink_pattern got %b expected %b", pat, blink_pat);
        end
        cyc();
        checks++;
        if (disp_on !== 1'b0) begin
            errors++;
            $display("FAIL blink_gap got %b expected 0", disp_on);
        end
        wait_idle("blink");
    endtask

    initial begin
`ifdef DOT_BLINK_EN
        blink_pat = 4'b1100;
`else
        blink_pat = 4'b1111;
`endif
        test_reset();
        test_single();
        test_simultaneous();
        test_overflow();
        test_clear();
        test_async_reset();
        test_blink();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
